// File: rtl/mouse_joy_port.sv
// mouse_joy_port: BK 177714 read value for joystick / PS2 mouse.
// Mouse deltas accumulate into sticky direction bits cleared by CPU writes.
module mouse_joy_port #(
  parameter int THRESH = 4,
  parameter int ACC_W  = 11
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wr_stb,
  input  logic [1:0]  wr_sel,
  input  logic [15:0] wr_data,
  input  logic [7:0]  mouse_counter,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic [7:0]  joystick,
  output logic [15:0] port_data,
  output logic        mouse_mode
);
  typedef logic signed [ACC_W-1:0] acc_t;

  logic [7:0]  last_cnt_q, last_cnt_d;
  logic        pkt_v_q, pkt_v_d;
  logic [8:0]  dx_q, dx_d;
  logic [8:0]  dy_q, dy_d;
  acc_t        acc_x_q, acc_x_d;
  acc_t        acc_y_q, acc_y_d;
  acc_t        base_x, base_y;
  logic [3:0]  dir_q, dir_d;
  logic        en_q, en_d;
  logic        mode_q, mode_d;
  logic [15:0] port_q, port_d;
  logic        wr, cnt_chg;
  logic        lat_u, lat_dn, lat_r, lat_l;
  logic        blk_y, blk_x;
  logic        unused_ok;

  // Add a 9-bit delta and clamp on overflow instead of wrapping
  function automatic acc_t sat_add(input acc_t a, input logic [8:0] d);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-8){d[8]}}, d};
    if (s[ACC_W] != s[ACC_W-1])
      return {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return s[ACC_W-1:0];
  endfunction

  assign wr      = wr_stb & wr_sel[0];
  assign cnt_chg = mouse_counter != last_cnt_q;

  assign blk_y  = dir_q[0] | dir_q[2];
  assign blk_x  = dir_q[1] | dir_q[3];
  assign lat_u  = ~blk_y & (int'(acc_y_q) >= THRESH);
  assign lat_dn = ~blk_y & (int'(acc_y_q) <= -THRESH);
  assign lat_r  = ~blk_x & (int'(acc_x_q) >= THRESH);
  assign lat_l  = ~blk_x & (int'(acc_x_q) <= -THRESH);

  assign unused_ok = ^{wr_sel[1], wr_data[15:4], wr_data[2:0]};

  // Capture, accumulate, latch and output selection
  always_comb begin
    last_cnt_d = mouse_counter;
    pkt_v_d    = cnt_chg & ~wr;
    dx_d       = cnt_chg ? pointer_dx : dx_q;
    dy_d       = cnt_chg ? pointer_dy : dy_q;
    en_d       = wr ? wr_data[3] : en_q;
    mode_d     = mode_q;
    if (joystick != '0)
      mode_d = 1'b0;
    else if (cnt_chg)
      mode_d = 1'b1;
    base_x  = (lat_r | lat_l) ? '0 : acc_x_q;
    base_y  = (lat_u | lat_dn) ? '0 : acc_y_q;
    acc_x_d = base_x;
    acc_y_d = base_y;
    if (pkt_v_q & en_q) begin
      acc_x_d = sat_add(base_x, dx_q);
      acc_y_d = sat_add(base_y, dy_q);
    end
    dir_d = dir_q | {lat_l, lat_dn, lat_r, lat_u};
    if (wr) begin
      dir_d   = '0;
      acc_x_d = '0;
      acc_y_d = '0;
    end
    if (mode_d)
      port_d = {9'b0, right_btn, left_btn, 1'b0, dir_q};
    else
      port_d = {8'b0, joystick};
  end

  // State registers; counter snapshot on reset avoids a phantom packet
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_cnt_q <= mouse_counter;
      pkt_v_q    <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      dir_q      <= '0;
      en_q       <= 1'b0;
      mode_q     <= 1'b0;
      port_q     <= '0;
    end else begin
      last_cnt_q <= last_cnt_d;
      pkt_v_q    <= pkt_v_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      port_q     <= port_d;
    end
  end

  assign port_data  = port_q;
  assign mouse_mode = mode_q;

endmodule

// File: tb/tb_mouse_joy_port.sv
// tb_mouse_joy_port: random + directed checks of mouse_joy_port
// against a packet-level reference model.
module tb_mouse_joy_port;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_stb;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  cnt;
  logic [8:0]  dx, dy;
  logic        lb, rb;
  logic [7:0]  joy;
  logic [15:0] pd, pd_s;
  logic        mm, mm_s;

  int n_cmp = 0;
  int n_bad = 0;

  bit       m_en, m_mode;
  bit [3:0] m_dir;
  int       m_ax, m_ay, s_ax;

  always #5 clk = ~clk;

  mouse_joy_port dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_data(wr_data),
    .mouse_counter(cnt), .pointer_dx(dx), .pointer_dy(dy),
    .left_btn(lb), .right_btn(rb), .joystick(joy),
    .port_data(pd), .mouse_mode(mm)
  );

  mouse_joy_port #(.THRESH(4000)) dut_s (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_data(wr_data),
    .mouse_counter(cnt), .pointer_dx(dx), .pointer_dy(dy),
    .left_btn(lb), .right_btn(rb), .joystick(joy),
    .port_data(pd_s), .mouse_mode(mm_s)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 1023) return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic logic [15:0] exp_pd();
    if (m_mode) return {9'b0, rb, lb, 1'b0, m_dir};
    return {8'b0, joy};
  endfunction

  function automatic void model_pkt(input int ddx, input int ddy);
    if (!m_en) return;
    m_ax = clamp(m_ax + ddx);
    m_ay = clamp(m_ay + ddy);
    s_ax = clamp(s_ax + ddx);
    if (!m_dir[0] && !m_dir[2]) begin
      if (m_ay >= T) begin m_dir[0] = 1'b1; m_ay = 0; end
      else if (m_ay <= -T) begin m_dir[2] = 1'b1; m_ay = 0; end
    end
    if (!m_dir[1] && !m_dir[3]) begin
      if (m_ax >= T) begin m_dir[1] = 1'b1; m_ax = 0; end
      else if (m_ax <= -T) begin m_dir[3] = 1'b1; m_ax = 0; end
    end
  endfunction

  function automatic void model_wr(input logic [15:0] d);
    m_en  = d[3];
    m_dir = '0;
    m_ax  = 0;
    m_ay  = 0;
    s_ax  = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input int ddx, input int ddy, input int settle);
    cnt = cnt + 8'($urandom_range(1, 3));
    dx  = 9'(ddx);
    dy  = 9'(ddy);
    m_mode = (joy == 8'h00);
    model_pkt(ddx, ddy);
    step();
    repeat (settle) step();
  endtask

  task automatic wr(input logic [15:0] d, input logic [1:0] s);
    wr_stb  = 1'b1;
    wr_data = d;
    wr_sel  = s;
    step();
    wr_stb = 1'b0;
    wr_sel = 2'b00;
    if (s[0]) model_wr(d);
    step();
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".pd"}, pd, exp_pd());
    chk({tag, ".mm"}, mm, m_mode);
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  rs;
    int          r, ddx, ddy;
    rst = 1'b1; wr_stb = 1'b0; wr_sel = 2'b00; wr_data = '0;
    cnt = 8'h37; dx = '0; dy = '0; lb = 1'b0; rb = 1'b0; joy = '0;
    m_en = 0; m_mode = 0; m_dir = '0; m_ax = 0; m_ay = 0; s_ax = 0;

    repeat (3) step();
    check_out("reset");
    rst = 1'b0;
    step();
    check_out("post_rst");

    joy = 8'h05;
    step();
    check_out("joy05");
    chk("joy05_lit", pd, 16'h0005);
    joy = 8'h00;
    step();

    wr(16'h0008, 2'b01);
    check_out("wr_en");
    cnt = cnt + 8'd1; dx = '0; dy = 9'd5;
    m_mode = 1;
    step();
    chk("mode_e0", mm, 1'b1);
    step();
    step();
    chk("lat_e2", pd[0], 1'b0);
    step();
    model_pkt(0, 5);
    check_out("dy5_e3");
    chk("dy5_bit", pd[0], 1'b1);
    chk("accy0", dut.acc_y_q, 32'd0);

    wr(16'h0008, 2'b01);
    pkt(-1, 0, 3);
    check_out("dxm1a");
    pkt(-1, 0, 3);
    check_out("dxm1b");
    pkt(-2, 0, 3);
    check_out("dxm2");
    pkt(9, 0, 3);
    check_out("blk");
    chk("blk_lit", pd[3:0], 4'b1000);

    wr(16'h0008, 2'b01);
    pkt(0, 5, 3);
    pkt(5, 0, 3);
    check_out("dir0011");
    wr_stb = 1'b1; wr_data = 16'h0000; wr_sel = 2'b01;
    cnt = cnt + 8'd1; dy = 9'd100;
    m_mode = 1;
    model_wr(16'h0000);
    step();
    wr_stb = 1'b0; wr_sel = 2'b00;
    repeat (3) step();
    check_out("wr_pkt");
    pkt(0, 100, 3);
    pkt(0, 100, 3);
    check_out("dis");
    chk("dis_lit", pd[3:0], 4'b0000);

    wr(16'h0008, 2'b01);
    repeat (12) pkt(255, 0, 1);
    repeat (2) step();
    chk("sat_pos", int'(dut_s.acc_x_q), s_ax);
    chk("sat_pos_lit", int'(dut_s.acc_x_q), 1023);
    check_out("sat_pos_pd");
    repeat (12) pkt(-256, 0, 1);
    repeat (2) step();
    chk("sat_neg", int'(dut_s.acc_x_q), -1024);
    lb = 1'b1;
    chk("lb_pre", pd[5], 1'b0);
    step();
    check_out("lb");
    chk("lb_bit", pd[5], 1'b1);
    rb = 1'b1;
    step();
    check_out("rb");
    lb = 1'b0; rb = 1'b0;
    step();

    wr(16'h0008, 2'b01);
    pkt(1, 0, 0);
    pkt(1, 0, 0);
    pkt(2, 0, 3);
    check_out("b2b");
    chk("b2b_lit", pd[3:0], 4'b0010);

    joy = 8'h10;
    pkt(3, 0, 0);
    chk("joy_pri", mm, 1'b0);
    joy = 8'h00;
    repeat (3) step();
    check_out("joy_pri2");

    wr(16'h0008, 2'b01);
    cnt = cnt + 8'd1; dx = '0; dy = 9'd50;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_en = 0; m_mode = 0; m_dir = '0; m_ax = 0; m_ay = 0; s_ax = 0;
    repeat (4) begin
      step();
      check_out("rst_mid");
      chk("rst_dir", dut.dir_q, 4'b0000);
    end

    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if ($urandom_range(0, 3) == 0) begin
          ddx = int'($urandom_range(0, 511)) - 256;
          ddy = int'($urandom_range(0, 511)) - 256;
        end else begin
          ddx = int'($urandom_range(0, 40)) - 20;
          ddy = int'($urandom_range(0, 40)) - 20;
        end
        pkt(ddx, ddy, 3);
      end else if (r <= 6) begin
        rd = 16'($urandom);
        rs = 2'($urandom);
        wr(rd, rs);
      end else if (r == 7) begin
        joy = 8'($urandom_range(1, 255));
        m_mode = 0;
        step();
        check_out("rnd_joy");
        joy = 8'h00;
        step();
      end else if (r == 8) begin
        lb = 1'($urandom);
        rb = 1'($urandom);
        step();
      end else begin
        step();
      end
      check_out("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
